// File: rtl/game_countdown_timer_if.sv
// Command/status bundle between the game state machine and the countdown timer.
// The master drives commands; the slave (timer) returns status and HUD digits.
interface game_countdown_timer_if;
   logic       start_in;
   logic       pause_in;
   logic       abort_in;
   logic [9:0] duration_in;
   logic       timer_done_out;
   logic       running_out;
   logic       tick_out;
   logic       warning_out;
   logic [9:0] seconds_left_out;
   logic [3:0] bcd_min_out;
   logic [3:0] bcd_tens_out;
   logic [3:0] bcd_ones_out;

   modport master (
      output start_in, pause_in, abort_in, duration_in,
      input  timer_done_out, running_out, tick_out, warning_out,
      input  seconds_left_out, bcd_min_out, bcd_tens_out, bcd_ones_out
   );

   modport slave (
      input  start_in, pause_in, abort_in, duration_in,
      output timer_done_out, running_out, tick_out, warning_out,
      output seconds_left_out, bcd_min_out, bcd_tens_out, bcd_ones_out
   );
endinterface

// File: rtl/game_countdown_timer.sv
// Countdown timer for timed game modes: whole-second prescaler, binary seconds count
// and BCD m:ss digits built by repeated subtraction, with pause/abort/restart.
module game_countdown_timer #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int GAME_SECONDS = 120,
   parameter int WARN_SECONDS = 10
) (
   input logic                   clk_in,
   input logic                   rst_n_in,
   game_countdown_timer_if.slave bus
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_RUN     = 3'd2;
   localparam logic [2:0] ST_PAUSED  = 3'd3;
   localparam logic [2:0] ST_EXPIRED = 3'd4;

   localparam int            PW           = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_LAST   = PW'(CLK_HZ - 1);
   localparam logic [9:0]    MAX_SECS     = 10'd599;
   localparam logic [9:0]    DEFAULT_SECS = 10'(GAME_SECONDS);
   localparam logic [9:0]    WARN_SECS    = 10'(WARN_SECONDS);

   logic [2:0]    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [9:0]    secs_q,  secs_d;
   logic [9:0]    rem_q,   rem_d;
   logic [3:0]    min_q,   min_d;
   logic [3:0]    tens_q,  tens_d;
   logic [3:0]    ones_q,  ones_d;
   logic          done_q,  done_d;
   logic          tick_q,  tick_d;
   logic [9:0]    dur_sel;
   logic [9:0]    dur_eff;
   logic          running;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      dur_sel = (bus.duration_in == '0) ? DEFAULT_SECS : bus.duration_in;
      dur_eff = (dur_sel > MAX_SECS) ? MAX_SECS : dur_sel;

      state_d = state_q;
      presc_d = presc_q;
      secs_d  = secs_q;
      rem_d   = rem_q;
      min_d   = min_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      done_d  = 1'b0;
      tick_d  = 1'b0;

      if (bus.abort_in) begin
         state_d = ST_IDLE;
         presc_d = '0;
         secs_d  = '0;
         rem_d   = '0;
         min_d   = '0;
         tens_d  = '0;
         ones_d  = '0;
      end else if (bus.start_in) begin
         state_d = ST_LOAD;
         presc_d = '0;
         secs_d  = dur_eff;
         rem_d   = dur_eff;
         min_d   = '0;
         tens_d  = '0;
         ones_d  = '0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (rem_q >= 10'd60) begin
                  rem_d = rem_q - 10'd60;
                  min_d = min_q + 4'd1;
               end else if (rem_q >= 10'd10) begin
                  rem_d  = rem_q - 10'd10;
                  tens_d = tens_q + 4'd1;
               end else begin
                  ones_d  = rem_q[3:0];
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
                  // A count of 1 (or a degenerate 0) expires here, so seconds never underflow.
                  if (secs_q <= 10'd1) begin
                     secs_d  = '0;
                     min_d   = '0;
                     tens_d  = '0;
                     ones_d  = '0;
                     done_d  = 1'b1;
                     state_d = ST_EXPIRED;
                  end else begin
                     secs_d = secs_q - 10'd1;
                     if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                     end else begin
                        ones_d = 4'd9;
                        if (tens_q != 4'd0) begin
                           tens_d = tens_q - 4'd1;
                        end else begin
                           tens_d = 4'd5;
                           min_d  = min_q - 4'd1;
                        end
                     end
                     if (bus.pause_in) state_d = ST_PAUSED;
                  end
               end else begin
                  presc_d = presc_q + 1'b1;
                  if (bus.pause_in) state_d = ST_PAUSED;
               end
            end
            ST_PAUSED: begin
               if (!bus.pause_in) state_d = ST_RUN;
            end
            ST_IDLE, ST_EXPIRED: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         secs_q  <= '0;
         rem_q   <= '0;
         min_q   <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
         done_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         secs_q  <= secs_d;
         rem_q   <= rem_d;
         min_q   <= min_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         done_q  <= done_d;
         tick_q  <= tick_d;
      end
   end

   assign running = (state_q == ST_RUN) || (state_q == ST_PAUSED);

   assign bus.timer_done_out   = done_q;
   assign bus.tick_out         = tick_q;
   assign bus.running_out      = running;
   assign bus.warning_out      = running && (secs_q != 10'd0) && (secs_q <= WARN_SECS);
   assign bus.seconds_left_out = secs_q;
   assign bus.bcd_min_out      = min_q;
   assign bus.bcd_tens_out     = tens_q;
   assign bus.bcd_ones_out     = ones_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer at CLK_HZ=4: a cycle-by-cycle vector table
// followed by hand-written sequences for hold, pause, restart, clamp, borrow and reset.
module tb_game_countdown_timer;

   typedef struct {
      logic       start;
      logic       pause;
      logic       abort;
      logic [9:0] dur;
      logic       done;
      logic       run;
      logic       tick;
      logic       warn;
      logic [9:0] secs;
      logic [3:0] mins;
      logic [3:0] tens;
      logic [3:0] ones;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   vec_t tbl[$];

   game_countdown_timer_if bus_if ();

   game_countdown_timer #(
      .CLK_HZ      (4),
      .GAME_SECONDS(120),
      .WARN_SECONDS(10)
   ) dut (
      .clk_in  (clk),
      .rst_n_in(rst_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [25:0] outs();
      return {bus_if.timer_done_out, bus_if.running_out, bus_if.tick_out, bus_if.warning_out,
              bus_if.seconds_left_out, bus_if.bcd_min_out, bus_if.bcd_tens_out,
              bus_if.bcd_ones_out};
   endfunction

   function automatic logic [25:0] ev(input logic dn, rn, tk, wn, input logic [9:0] sc,
                                      input logic [3:0] mi, te, on);
      return {dn, rn, tk, wn, sc, mi, te, on};
   endfunction

   task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got done/run/tick/warn=%b%b%b%b secs=%0d bcd=%0d%0d%0d, want done/run/tick/warn=%b%b%b%b secs=%0d bcd=%0d%0d%0d",
                  name, act[25], act[24], act[23], act[22], act[21:12], act[11:8], act[7:4], act[3:0],
                  exp[25], exp[24], exp[23], exp[22], exp[21:12], exp[11:8], exp[7:4], exp[3:0]);
      end
   endtask

   task automatic add(input logic st, pa, ab, input logic [9:0] du,
                      input logic dn, rn, tk, wn, input logic [9:0] sc,
                      input logic [3:0] mi, te, on);
      vec_t v;
      v = '{st, pa, ab, du, dn, rn, tk, wn, sc, mi, te, on};
      tbl.push_back(v);
   endtask

   task automatic drive(input logic st, pa, ab, input logic [9:0] du);
      bus_if.start_in    = st;
      bus_if.pause_in    = pa;
      bus_if.abort_in    = ab;
      bus_if.duration_in = du;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      drive(1'b0, 1'b0, 1'b0, 10'd0);
      rst_n = 1'b0;

      // Default duration 120: 3 LOAD cycles, 4 RUN cycles to the first tick.
      add(1,0,0,10'd0,   0,0,0,0,10'd120,4'd0,4'd0,4'd0);
      add(0,0,0,10'd0,   0,0,0,0,10'd120,4'd1,4'd0,4'd0);
      add(0,0,0,10'd0,   0,0,0,0,10'd120,4'd2,4'd0,4'd0);
      add(0,0,0,10'd0,   0,1,0,0,10'd120,4'd2,4'd0,4'd0);
      add(0,0,0,10'd0,   0,1,0,0,10'd120,4'd2,4'd0,4'd0);
      add(0,0,0,10'd0,   0,1,0,0,10'd120,4'd2,4'd0,4'd0);
      add(0,0,0,10'd0,   0,1,0,0,10'd120,4'd2,4'd0,4'd0);
      add(0,0,0,10'd0,   0,1,1,0,10'd119,4'd1,4'd5,4'd9);
      add(0,0,0,10'd0,   0,1,0,0,10'd119,4'd1,4'd5,4'd9);
      // Abort together with start during RUN.
      add(1,0,1,10'd5,   0,0,0,0,10'd0,  4'd0,4'd0,4'd0);
      add(0,0,0,10'd0,   0,0,0,0,10'd0,  4'd0,4'd0,4'd0);
      // Duration 2 runs to expiry with warning high throughout RUN.
      add(1,0,0,10'd2,   0,0,0,0,10'd2,  4'd0,4'd0,4'd0);
      add(0,0,0,10'd0,   0,1,0,1,10'd2,  4'd0,4'd0,4'd2);
      add(0,0,0,10'd0,   0,1,0,1,10'd2,  4'd0,4'd0,4'd2);
      add(0,0,0,10'd0,   0,1,0,1,10'd2,  4'd0,4'd0,4'd2);
      add(0,0,0,10'd0,   0,1,0,1,10'd2,  4'd0,4'd0,4'd2);
      add(0,0,0,10'd0,   0,1,1,1,10'd1,  4'd0,4'd0,4'd1);
      add(0,0,0,10'd0,   0,1,0,1,10'd1,  4'd0,4'd0,4'd1);
      add(0,0,0,10'd0,   0,1,0,1,10'd1,  4'd0,4'd0,4'd1);
      add(0,0,0,10'd0,   0,1,0,1,10'd1,  4'd0,4'd0,4'd1);
      add(0,0,0,10'd0,   1,0,1,0,10'd0,  4'd0,4'd0,4'd0);
      add(0,0,0,10'd0,   0,0,0,0,10'd0,  4'd0,4'd0,4'd0);

      repeat (3) @(posedge clk);
      #1;
      check("reset_asserted", outs(), '0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      check("reset_released", outs(), '0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].start, tbl[i].pause, tbl[i].abort, tbl[i].dur);
         cycle();
         check($sformatf("vec%0d", i), outs(),
               ev(tbl[i].done, tbl[i].run, tbl[i].tick, tbl[i].warn,
                  tbl[i].secs, tbl[i].mins, tbl[i].tens, tbl[i].ones));
      end
      drive(1'b0, 1'b0, 1'b0, 10'd0);

      // EXPIRED holds quietly until start or abort.
      for (int i = 0; i < 20; i++) begin
         cycle();
         check($sformatf("expired_hold%0d", i), outs(), '0);
      end

      // Pause with the prescaler at 2 and 5 seconds left.
      drive(1'b1, 1'b0, 1'b0, 10'd5);
      cycle();
      check("pause_load", outs(), ev(0,0,0,0,10'd5,4'd0,4'd0,4'd0));
      drive(1'b0, 1'b0, 1'b0, 10'd0);
      cycle();
      check("pause_run_p0", outs(), ev(0,1,0,1,10'd5,4'd0,4'd0,4'd5));
      cycle();
      check("pause_run_p1", outs(), ev(0,1,0,1,10'd5,4'd0,4'd0,4'd5));
      drive(1'b0, 1'b1, 1'b0, 10'd0);
      cycle();
      check("pause_enter", outs(), ev(0,1,0,1,10'd5,4'd0,4'd0,4'd5));
      for (int i = 0; i < 10; i++) begin
         cycle();
         check($sformatf("pause_hold%0d", i), outs(), ev(0,1,0,1,10'd5,4'd0,4'd0,4'd5));
      end
      drive(1'b0, 1'b0, 1'b0, 10'd0);
      cycle();
      check("pause_release", outs(), ev(0,1,0,1,10'd5,4'd0,4'd0,4'd5));
      cycle();
      check("pause_resume1", outs(), ev(0,1,0,1,10'd5,4'd0,4'd0,4'd5));
      cycle();
      check("pause_tick", outs(), ev(0,1,1,1,10'd4,4'd0,4'd0,4'd4));

      // Start on the expiry-wrap cycle of a 1-second run wins; no done pulse.
      drive(1'b1, 1'b0, 1'b0, 10'd1);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 10'd0);
      cycle();
      check("wrap_start_run", outs(), ev(0,1,0,1,10'd1,4'd0,4'd0,4'd1));
      repeat (3) cycle();
      check("wrap_start_pre", outs(), ev(0,1,0,1,10'd1,4'd0,4'd0,4'd1));
      drive(1'b1, 1'b0, 1'b0, 10'd3);
      cycle();
      check("wrap_start_load", outs(), ev(0,0,0,0,10'd3,4'd0,4'd0,4'd0));
      drive(1'b0, 1'b0, 1'b0, 10'd0);
      cycle();
      check("wrap_start_run3", outs(), ev(0,1,0,1,10'd3,4'd0,4'd0,4'd3));

      // Clamp 700 -> 599: 15 LOAD cycles.
      drive(1'b1, 1'b0, 1'b0, 10'd700);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 10'd0);
      repeat (14) cycle();
      check("clamp_load14", outs(), ev(0,0,0,0,10'd599,4'd9,4'd5,4'd0));
      cycle();
      check("clamp_run", outs(), ev(0,1,0,0,10'd599,4'd9,4'd5,4'd9));

      // 60 seconds: borrow through tens into minutes on the first tick.
      drive(1'b1, 1'b0, 1'b0, 10'd60);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 10'd0);
      repeat (2) cycle();
      check("borrow_run", outs(), ev(0,1,0,0,10'd60,4'd1,4'd0,4'd0));
      repeat (4) cycle();
      check("borrow_tick", outs(), ev(0,1,1,0,10'd59,4'd0,4'd5,4'd9));

      // Asynchronous reset mid-RUN, then 20 quiet cycles after release.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", outs(), '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         check($sformatf("post_reset%0d", i), outs(), '0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/game_countdown_timer.md
# game_countdown_timer

Countdown timer for timed maze game modes. It is started by the game state machine's `start_timer` pulse and returns a single-cycle `timer_done` pulse at expiry. Between those points it counts whole seconds from a clock prescaler and keeps the remaining time as BCD minutes/seconds digits for the HUD overlay. It also supports pause, abort and restart.

## Interface
- `CLK_HZ`, default 100_000_000: clock cycles per second (prescaler period).
- `GAME_SECONDS`, default 120: duration used when `duration_in` is 0.
- `WARN_SECONDS`, default 10: low-time warning threshold.

- `clk_in`  input  1  system clock; the block uses this one clock only.
- `rst_n_in`  input  1  asynchronous, active-low reset.
- `start_in`  input  1  pulse; load the duration and start counting.
- `pause_in`  input  1  level; freeze counting while high.
- `abort_in`  input  1  pulse; stop and clear.
- `duration_in`  input  10  seconds, sampled on the `start_in` cycle; 0 selects `GAME_SECONDS`, values >599 clamp to 599.
- `timer_done_out`  output  1  one-cycle pulse at expiry.
- `running_out`  output  1  high in RUN or PAUSED.
- `tick_out`  output  1  one-cycle pulse on each second decrement.
- `warning_out`  output  1  high in RUN/PAUSED when 0 < `seconds_left_out` ≤ `WARN_SECONDS`.
- `seconds_left_out`  output  10  remaining seconds, binary.
- `bcd_min_out`  output  4  minutes digit, 0–9.
- `bcd_tens_out`  output  4  seconds tens digit, 0–5.
- `bcd_ones_out`  output  4  seconds ones digit, 0–9.

## Operation
- **States:** IDLE, LOAD, RUN, PAUSED, EXPIRED.
- **Command priority** (applies in every state): `abort_in` > `start_in` > `pause_in`.
- **Abort:** go to IDLE. Clear the seconds count, all digits and the prescaler. No done pulse.
- **Start:** latch the effective duration into `seconds_left` and into a conversion remainder; zero the digits and the prescaler; go to LOAD. A start in RUN, PAUSED or EXPIRED restarts the timer the same way.
- **LOAD:** one step of binary-to-BCD conversion per cycle, by repeated subtraction. No divider is permitted.
  - If rem ≥ 60: rem −= 60, min++.
  - Else if rem ≥ 10: rem −= 10, tens++.
  - Else: ones = rem, go to RUN.
- **RUN:**
  - Prescaler counts 0…`CLK_HZ`−1 and wraps.
  - On the wrap cycle: pulse `tick_out`, decrement `seconds_left` and decrement the BCD digits with borrow (ones 0→9 borrows tens; tens 0→5 borrows min).
  - If `seconds_left` was 1: go to EXPIRED and pulse `timer_done_out`.
  - If `pause_in` is high (and there is no wrap in the same cycle): go to PAUSED.
- **PAUSED:** prescaler and digits hold. When `pause_in` is low, return to RUN; the prescaler resumes from its held value.
- **EXPIRED:** `seconds_left` and all digits stay 0. Remain in EXPIRED until start or abort.
- **Width rules:**
  - Prescaler width is `$clog2(CLK_HZ)`.
  - `seconds_left` never underflows.
  - BCD digits always equal the decimal form of `seconds_left` in RUN, PAUSED and EXPIRED.

## Timing
- **Reset values:** all outputs 0; state IDLE; prescaler 0. Reset asserted mid-LOAD or mid-RUN clears immediately and asynchronously.
- **Start latency:** `start_in` sampled at edge N → LOAD from N. LOAD lasts min + tens + 1 cycles. `running_out` goes high on the edge entering RUN.
- **First tick:** the first wrap occurs `CLK_HZ` cycles after entering RUN.
- **Expiry cycle:** `timer_done_out`, `tick_out`, `seconds_left_out`=0 and the EXPIRED state all become visible on the same edge. `running_out` falls on that same edge.
- **Pause latency:** `pause_in` takes effect at the next edge. A wrap in the same cycle as pause still decrements, then enters PAUSED.
- **Same-cycle conflicts:**
  - A start coinciding with a wrap or expiry wins; no done pulse is produced.
  - An abort always wins over everything.
- **Output timing:** all outputs are registered. `warning_out` is derived from registered state.

## Test plan
All scenarios use `CLK_HZ`=4, `GAME_SECONDS`=120, `WARN_SECONDS`=10.
- **Reset:** assert `rst_n_in` low mid-RUN → all outputs 0 asynchronously; after release, state stays IDLE and `tick_out` stays 0 for 20 cycles.
- **Default duration:** `start_in` with `duration_in`=0 → 3 LOAD cycles; then digits 2/0/0 and `seconds_left`=120; 4 cycles later `tick_out` pulses and digits read 1/5/9 with `seconds_left`=119.
- **Expiry:** `duration_in`=2 → after LOAD, 8 RUN cycles; `timer_done_out` high for exactly 1 cycle, `seconds_left`=0, `running_out`=0, EXPIRED held for 20 cycles with no further pulses; `warning_out` high throughout RUN.
- **Pause:** pause held for 10 cycles with prescaler at 2, `seconds_left`=5 → values unchanged; the next tick comes 2 cycles after release.
- **Abort/start conflict:** `abort_in` and `start_in` in the same cycle during RUN → IDLE, all outputs 0, no done pulse. Separately, `start_in` on the expiry-wrap cycle with `duration_in`=3 → LOAD, no done pulse.
- **Clamp and borrow:** `duration_in`=700 → clamps to 599, digits 9/5/9 after 15 LOAD cycles. `duration_in`=60 → digits 1/0/0; after the first tick, digits 0/5/9 and `seconds_left`=59.
